dp_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-register ALU datapath. It accepts one 16-bit instruction word at a time over a valid/ready handshake and decodes it into ALU opcode, Rdest/Rsrc selects, immediate value and immediate select. It issues a single-cycle one-hot register write enable and latches the ALU flags into an architectural flag register. It sits between the instruction source (memory/FSM above) and the datapath, and is the only driver of the datapath control inputs.

---
 rtl/dp_seq_pkg.sv | 33 +++
 rtl/dp_sequencer_if.sv | 29 ++
 rtl/dp_instr_decode.sv | 49 ++++
 rtl/dp_sequencer.sv | 96 +++++++++
 tb/tb_dp_sequencer.sv | 137 +++++++++++++
 5 files changed

// File: rtl/dp_seq_pkg.sv
// Shared types and field constants for the datapath instruction sequencer.
package dp_seq_pkg;

  localparam int unsigned IW = 16;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RD_MSB    = 11;
  localparam int unsigned RD_LSB    = 8;
  localparam int unsigned OPEXT_MSB = 7;
  localparam int unsigned OPEXT_LSB = 4;
  localparam int unsigned RS_MSB    = 3;
  localparam int unsigned RS_LSB    = 0;
  localparam int unsigned IMM_MSB   = 7;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [3:0] OP_RTYPE   = 4'h0;
  localparam logic [3:0] OP_ILLEGAL = 4'hF;
  localparam logic [3:0] OPEXT_NOP  = 4'h0;

  typedef enum logic [1:0] {StIdle, StDecode, StExecute, StRetire} state_e;

  typedef enum logic [1:0] {ClsNop, ClsCmp, ClsAluWr, ClsIllegal} instr_class_e;

  function automatic logic class_writes(instr_class_e cls);
    return cls == ClsAluWr;
  endfunction

  function automatic logic class_captures(instr_class_e cls);
    return (cls == ClsAluWr) || (cls == ClsCmp);
  endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Instruction handshake and datapath control bundle around the sequencer.
interface dp_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select;
  logic [3:0]  Rsrc_select;
  logic        Imm_select;
  logic [15:0] Imm_in;
  logic [4:0]  flags_q;
  logic        done;
  logic        err;

  // master: instruction source plus datapath; slave: the sequencer itself
  modport master (
    output instr, instr_valid, flags_in,
    input  instr_ready, wEnable, opcode, Rdest_select, Rsrc_select, Imm_select, Imm_in,
    input  flags_q, done, err
  );

  modport slave (
    input  instr, instr_valid, flags_in,
    output instr_ready, wEnable, opcode, Rdest_select, Rsrc_select, Imm_select, Imm_in,
    output flags_q, done, err
  );
endinterface

// File: rtl/dp_instr_decode.sv
// Combinational decode of the registered instruction word into datapath controls.
module dp_instr_decode
  import dp_seq_pkg::*;
#(
  parameter logic [3:0]  CMP_CODE  = 4'hB,
  parameter logic [15:0] ZEXT_MASK = 16'h000E
) (
  input  logic [IW-1:0] ir,
  output logic [7:0]    opcode,
  output logic [3:0]    rdest,
  output logic [3:0]    rsrc,
  output logic          imm_select,
  output logic [15:0]   imm_in,
  output instr_class_e  instr_class
);

  logic [3:0] op;
  logic [3:0] opext;
  logic [7:0] imm8;

  assign op    = ir[OP_MSB:OP_LSB];
  assign opext = ir[OPEXT_MSB:OPEXT_LSB];
  assign imm8  = ir[IMM_MSB:IMM_LSB];

  always_comb begin
    opcode      = '0;
    rdest       = ir[RD_MSB:RD_LSB];
    rsrc        = '0;
    imm_select  = 1'b0;
    imm_in      = '0;
    instr_class = ClsNop;
    if (op == OP_RTYPE) begin
      opcode = {4'h0, opext};
      rsrc   = ir[RS_MSB:RS_LSB];
      if (opext == OPEXT_NOP)     instr_class = ClsNop;
      else if (opext == CMP_CODE) instr_class = ClsCmp;
      else                        instr_class = ClsAluWr;
    end else if (op == OP_ILLEGAL) begin
      // Illegal words drive no ALU operation; only rd passes through.
      instr_class = ClsIllegal;
    end else begin
      opcode      = {op, 4'h0};
      imm_select  = 1'b1;
      imm_in      = ZEXT_MASK[op] ? {8'h00, imm8} : {{8{imm8[7]}}, imm8};
      instr_class = (op == CMP_CODE) ? ClsCmp : ClsAluWr;
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Four-state instruction sequencer: accept, decode/settle, write+flag capture, retire.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [3:0]  CMP_CODE  = 4'hB,
  parameter logic [15:0] ZEXT_MASK = 16'h000E
) (
  input logic          clk,
  input logic          reset,
  dp_sequencer_if.slave bus
);

  state_e             state_q;
  logic [WIDTH-1:0]   ir_q;
  logic               ready_q;
  logic [WIDTH-1:0]   wen_q;
  logic [4:0]         flags_q;
  logic               done_q;
  logic               err_q;

  logic [7:0]         opcode;
  logic [3:0]         rdest;
  logic [3:0]         rsrc;
  logic               imm_select;
  logic [15:0]        imm_in;
  instr_class_e       cls;

  dp_instr_decode #(
    .CMP_CODE  (CMP_CODE),
    .ZEXT_MASK (ZEXT_MASK)
  ) u_decode (
    .ir          (ir_q),
    .opcode      (opcode),
    .rdest       (rdest),
    .rsrc        (rsrc),
    .imm_select  (imm_select),
    .imm_in      (imm_in),
    .instr_class (cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      ready_q <= 1'b0;
      wen_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // ready_q is held low through reset and rises on the first edge after it
          if (ready_q && bus.instr_valid) begin
            ir_q    <= bus.instr;
            ready_q <= 1'b0;
            state_q <= StDecode;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StDecode: begin
          if (class_writes(cls)) wen_q <= WIDTH'(1) << rdest;
          state_q <= StExecute;
        end
        StExecute: begin
          wen_q <= '0;
          if (class_captures(cls)) flags_q <= bus.flags_in;
          done_q  <= 1'b1;
          err_q   <= (cls == ClsIllegal);
          state_q <= StRetire;
        end
        StRetire: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.wEnable      = wen_q;
  assign bus.opcode       = opcode;
  assign bus.Rdest_select = rdest;
  assign bus.Rsrc_select  = rsrc;
  assign bus.Imm_select   = imm_select;
  assign bus.Imm_in       = imm_in;
  assign bus.flags_q      = flags_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer.
module tb_dp_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  dp_sequencer_if bus ();

  dp_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE and check every phase through RETIRE.
  task automatic run_instr(input string name, input logic [15:0] ins, input logic [4:0] flg,
                           input logic [7:0] e_op, input logic [3:0] e_rd, input logic [3:0] e_rs,
                           input logic e_isel, input logic [15:0] e_imm, input logic [15:0] e_wen,
                           input logic [4:0] e_flags, input logic e_err);
    chk({name, " ready"}, 16'(bus.instr_ready), 16'h1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.flags_in    = flg;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk({name, " dec ready"}, 16'(bus.instr_ready), 16'h0);
    chk({name, " opcode"}, 16'(bus.opcode), 16'(e_op));
    chk({name, " rdest"}, 16'(bus.Rdest_select), 16'(e_rd));
    chk({name, " rsrc"}, 16'(bus.Rsrc_select), 16'(e_rs));
    chk({name, " isel"}, 16'(bus.Imm_select), 16'(e_isel));
    chk({name, " imm"}, bus.Imm_in, e_imm);
    chk({name, " dec wen"}, bus.wEnable, 16'h0);
    @(negedge clk);
    chk({name, " exe wen"}, bus.wEnable, e_wen);
    chk({name, " exe opcode"}, 16'(bus.opcode), 16'(e_op));
    chk({name, " exe done"}, 16'(bus.done), 16'h0);
    @(negedge clk);
    chk({name, " ret wen"}, bus.wEnable, 16'h0);
    chk({name, " ret done"}, 16'(bus.done), 16'h1);
    chk({name, " ret err"}, 16'(bus.err), 16'(e_err));
    chk({name, " flags"}, 16'(bus.flags_q), 16'(e_flags));
    @(negedge clk);
    chk({name, " idle done"}, 16'(bus.done), 16'h0);
    chk({name, " idle err"}, 16'(bus.err), 16'h0);
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.instr       = 16'h0;
    bus.instr_valid = 1'b0;
    bus.flags_in    = 5'h0;

    repeat (2) @(negedge clk);
    chk("rst ready", 16'(bus.instr_ready), 16'h0);
    chk("rst wen", bus.wEnable, 16'h0);
    chk("rst flags", 16'(bus.flags_q), 16'h0);
    chk("rst done", 16'(bus.done), 16'h0);
    chk("rst err", 16'(bus.err), 16'h0);
    chk("rst opcode", 16'(bus.opcode), 16'h0);
    chk("rst isel", 16'(bus.Imm_select), 16'h0);

    reset = 1'b1;
    @(negedge clk);

    run_instr("add", 16'h0352, 5'b00110, 8'h05, 4'h3, 4'h2, 1'b0, 16'h0000, 16'h0008,
              5'b00110, 1'b0);
    run_instr("sxi", 16'h5A80, 5'b11001, 8'h50, 4'hA, 4'h0, 1'b1, 16'hFF80, 16'h0400,
              5'b11001, 1'b0);
    run_instr("ori", 16'h2180, 5'b00011, 8'h20, 4'h1, 4'h0, 1'b1, 16'h0080, 16'h0002,
              5'b00011, 1'b0);
    run_instr("cmp", 16'h04B7, 5'b10101, 8'h0B, 4'h4, 4'h7, 1'b0, 16'h0000, 16'h0000,
              5'b10101, 1'b0);
    run_instr("nop", 16'h0000, 5'b01010, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000,
              5'b10101, 1'b0);
    run_instr("ill", 16'hF123, 5'b01111, 8'h00, 4'h1, 4'h0, 1'b0, 16'h0000, 16'h0000,
              5'b10101, 1'b1);
    run_instr("cmpi", 16'hB512, 5'b00111, 8'hB0, 4'h5, 4'h0, 1'b1, 16'h0012, 16'h0000,
              5'b00111, 1'b0);
    run_instr("wr_r0", 16'h0010, 5'b11111, 8'h01, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0001,
              5'b11111, 1'b0);

    // Reset in the middle of EXECUTE.
    bus.instr       = 16'h0352;
    bus.instr_valid = 1'b1;
    bus.flags_in    = 5'b11100;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("mid exe wen", bus.wEnable, 16'h0008);
    reset = 1'b0;
    #1;
    chk("mid rst wen", bus.wEnable, 16'h0);
    chk("mid rst flags", 16'(bus.flags_q), 16'h0);
    chk("mid rst ready", 16'(bus.instr_ready), 16'h0);
    chk("mid rst done", 16'(bus.done), 16'h0);
    chk("mid rst opcode", 16'(bus.opcode), 16'h0);
    @(negedge clk);
    chk("mid hold wen", bus.wEnable, 16'h0);
    chk("mid hold flags", 16'(bus.flags_q), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("post rst ready", 16'(bus.instr_ready), 16'h1);
    chk("post rst flags", 16'(bus.flags_q), 16'h0);

    // Back-to-back: valid held high, accepts every 4 cycles.
    bus.instr       = 16'h0121;
    bus.instr_valid = 1'b1;
    bus.flags_in    = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ready %0d", k), 16'(bus.instr_ready), (k % 4 == 0) ? 16'h1 : 16'h0);
      chk($sformatf("b2b wen %0d", k), bus.wEnable, (k % 4 == 2) ? 16'h0002 : 16'h0000);
      chk($sformatf("b2b done %0d", k), 16'(bus.done), (k % 4 == 3) ? 16'h1 : 16'h0);
    end
    bus.instr_valid = 1'b0;
    chk("b2b flags", 16'(bus.flags_q), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
